// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// MULTDIV_RADIX4_BOOTH_EN selects radix-4 Booth multiply (16 iterations instead of 32).
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

`ifdef MULTDIV_RADIX4_BOOTH_EN
  localparam int MULT_ITERS = 16;
  // A +/-2A partial product needs two guard bits above the 32-bit accumulator
  localparam int ADD_W      = 34;
`else
  localparam int MULT_ITERS = 32;
  localparam int ADD_W      = 33;
`endif
  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    logic [31:0] m;
    if (v[31]) m = ~v + 32'd1;
    else       m = v;
    return m;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;
  logic              busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_counter.sv
// 6-bit iteration counter with synchronous clear; o_tc flags the final iteration.
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [5:0] i_last,
  output logic       o_tc
);

  logic [5:0] r_cnt;

  // Count iterations: cleared on every start, advanced once per iteration edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 6'd0;
    end else if (i_clr) begin
      r_cnt <= 6'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 6'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply (Booth) / divide (restoring) unit.
// MULTDIV_RADIX4_BOOTH_EN switches multiply to radix-4 Booth; results are identical.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  state_e            r_state;
  logic [64:0]       r_p;
  logic [31:0]       r_opnd;
  logic              r_is_div;
  logic              r_neg;
  logic              r_dbz;
  logic              r_ovf;
  logic [DATA_W-1:0] r_result;
  logic              r_exc;
  logic              r_rdy;
  logic              r_busy;

  logic              w_start;
  logic              w_iter;
  logic              w_tc;
  logic [5:0]        w_last;
  logic              w_sub;
  logic [ADD_W-1:0]  w_add_a;
  logic [ADD_W-1:0]  w_add_b;
  logic [ADD_W-1:0]  w_sum;
  logic [64:0]       w_p_next;
  logic [31:0]       w_quot;

  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_iter  = (r_state == S_MULT) || (r_state == S_DIV);
  assign w_last  = (r_state == S_MULT) ? 6'(MULT_ITERS - 1) : 6'(DIV_ITERS - 1);
  assign w_quot  = r_neg ? (~r_p[31:0] + 32'd1) : r_p[31:0];

  multdiv_counter u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_start),
    .i_en    (w_iter & ~w_start),
    .i_last  (w_last),
    .o_tc    (w_tc)
  );

  // Shared adder/subtractor and next value of the 65-bit shift register
  always_comb begin
    w_add_a  = '0;
    w_add_b  = '0;
    w_sub    = 1'b0;
    case (r_state)
      S_MULT: begin
        w_add_a = ADD_W'($signed(r_p[64:33]));
`ifdef MULTDIV_RADIX4_BOOTH_EN
        case (r_p[2:0])
          3'b001, 3'b010: w_add_b = ADD_W'($signed(r_opnd));
          3'b011:         w_add_b = ADD_W'($signed({r_opnd, 1'b0}));
          3'b100: begin
            w_add_b = ADD_W'($signed({r_opnd, 1'b0}));
            w_sub   = 1'b1;
          end
          3'b101, 3'b110: begin
            w_add_b = ADD_W'($signed(r_opnd));
            w_sub   = 1'b1;
          end
          default:        w_add_b = '0;
        endcase
`else
        case (r_p[1:0])
          2'b01:   w_add_b = ADD_W'($signed(r_opnd));
          2'b10: begin
            w_add_b = ADD_W'($signed(r_opnd));
            w_sub   = 1'b1;
          end
          default: w_add_b = '0;
        endcase
`endif
      end
      S_DIV: begin
        // Trial subtract of the divisor from the left-shifted partial remainder
        w_add_a = ADD_W'(r_p[63:31]);
        w_add_b = ADD_W'(r_opnd);
        w_sub   = 1'b1;
      end
      default: begin
        w_add_a = '0;
        w_add_b = '0;
        w_sub   = 1'b0;
      end
    endcase

    if (w_sub) w_sum = w_add_a - w_add_b;
    else       w_sum = w_add_a + w_add_b;

    w_p_next = r_p;
    if (r_state == S_MULT) begin
`ifdef MULTDIV_RADIX4_BOOTH_EN
      w_p_next = {w_sum, r_p[32:2]};
`else
      w_p_next = {w_sum, r_p[32:1]};
`endif
    end else if (r_state == S_DIV) begin
      if (w_sum[ADD_W-1]) w_p_next = {r_p[63:0], 1'b0};
      else                w_p_next = {w_sum[32:0], r_p[30:0], 1'b1};
    end else begin
      w_p_next = r_p;
    end
  end

  // Control FSM, operand capture, iteration datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_p      <= 65'd0;
      r_opnd   <= 32'd0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        // A start in any state aborts the current operation; multiply wins ties
        r_busy   <= 1'b1;
        r_is_div <= ~bus.ctrl_MULT;
        if (bus.ctrl_MULT) begin
          r_state <= S_MULT;
          r_opnd  <= bus.data_operandA;
          r_p     <= {32'd0, bus.data_operandB, 1'b0};
          r_neg   <= 1'b0;
          r_dbz   <= 1'b0;
          r_ovf   <= 1'b0;
        end else begin
          r_state <= S_DIV;
          r_opnd  <= magnitude(bus.data_operandB);
          r_p     <= {33'd0, magnitude(bus.data_operandA)};
          r_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
          r_dbz   <= (bus.data_operandB == 32'd0);
          r_ovf   <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == 32'hFFFF_FFFF);
        end
      end else begin
        case (r_state)
          S_MULT, S_DIV: begin
            r_p <= w_p_next;
            if (w_tc) r_state <= S_DONE;
            else      r_state <= r_state;
          end
          S_DONE: begin
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
            if (r_is_div) begin
              if (r_dbz) begin
                r_result <= '0;
                r_exc    <= 1'b1;
              end else begin
                r_result <= w_quot;
                r_exc    <= r_ovf;
              end
            end else begin
              r_result <= r_p[32:1];
              r_exc    <= ~((&r_p[64:32]) | ~(|r_p[64:32]));
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule
